// File: rtl/cluster_eval_arbiter.sv
// Round-robin arbiter that shares one combinational evaluation datapath among
// NREQ requesters. It holds each request for a programmable settle time, then returns the captured result.
module cluster_eval_arbiter #(
  parameter  int IN_W  = 1894,
  parameter  int OUT_W = 128,
  parameter  int NREQ  = 4,
  localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*IN_W-1:0]   req_vec,
  output logic [IN_W-1:0]        eval_i,
  input  logic [OUT_W-1:0]       eval_o,
  input  logic [3:0]             settle_cycles,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [OUT_W-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  // state  | meaning
  // IDLE   | waiting for a request; req_ready grants combinationally
  // SETTLE | eval_i driven, counting down settle cycles
  // RESP   | result held on rsp_* until rsp_ready
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr;
  logic [3:0]      cnt;
  logic            grant_any;
  logic [ID_W-1:0] grant_idx;
  logic [IN_W-1:0] sel_vec;
  logic            accept;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int j;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_any && req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  always_comb begin
    sel_vec = req_vec[IN_W-1:0];
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == ID_W'(k)) sel_vec = req_vec[k*IN_W +: IN_W];
    end
  end

  assign accept = (state == IDLE) && grant_any;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready is gated by rst so nothing is granted while reset is held.
  always_comb begin
    req_ready = '0;
    if (accept && !rst) req_ready[grant_idx] = 1'b1;
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      eval_i   <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      if (accept) begin
        eval_i <= sel_vec;
        rsp_id <= grant_idx;
        cnt    <= settle_cycles;
        rr_ptr <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end else if (state == SETTLE) begin
        if (cnt != 4'd0) cnt      <= cnt - 4'd1;
        else             rsp_data <= eval_o;
      end
    end
  end

endmodule

// File: tb/tb_cluster_eval_arbiter.sv
// Scoreboard bench for cluster_eval_arbiter: expected {id, data} pushed at
// request time, popped and compared when the response appears.
module tb_cluster_eval_arbiter;
  localparam int IN_W  = 1894;
  localparam int OUT_W = 128;
  localparam int NREQ  = 4;
  localparam int ID_W  = 2;

  logic                 clk, rst;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*IN_W-1:0] req_vec;
  logic [IN_W-1:0]      eval_i;
  logic [OUT_W-1:0]     eval_o;
  logic [3:0]           settle_cycles;
  logic                 rsp_valid, rsp_ready, busy;
  logic [OUT_W-1:0]     rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic                 ovr_en;
  logic [OUT_W-1:0]     ovr_val;

  typedef struct { logic [ID_W-1:0] id; logic [OUT_W-1:0] data; } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [OUT_W-1:0] eval_fn(input logic [IN_W-1:0] v);
    return v[OUT_W-1:0] ^ v[IN_W-1 -: OUT_W];
  endfunction

  function automatic logic [IN_W-1:0] slot(input int k);
    return req_vec[k*IN_W +: IN_W];
  endfunction

  assign eval_o = ovr_en ? ovr_val : eval_fn(eval_i);

  cluster_eval_arbiter #(.IN_W(IN_W), .OUT_W(OUT_W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .eval_i(eval_i), .eval_o(eval_o),
    .settle_cycles(settle_cycles), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; ovr_en = 1'b0;
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset;
    req_valid = 4'hF; rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0000", req_ready); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (eval_i !== '0) begin n_err++; $display("FAIL rst_eval_i: nonzero"); end
    n_vec++; if (rsp_data !== '0) begin n_err++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
    n_vec++; if (rsp_id !== '0) begin n_err++; $display("FAIL rst_rsp_id: got %0d want 0", rsp_id); end
  endtask

  task automatic test_single;
    int n; exp_t e;
    do_reset();
    settle_cycles = 4'd3; ovr_en = 1'b1; ovr_val = 128'hA5;
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    sb.push_back('{id: 2'd2, data: 128'hA5});
    step();
    req_valid = 4'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL single_ready_drop: got %b want 0000", req_ready); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    n_vec++; if (eval_i !== slot(2)) begin n_err++; $display("FAIL single_eval_i_load: wrong vector"); end
    wait_rsp(n);
    n_vec++; if (n != 4) begin n_err++; $display("FAIL single_latency: got %0d want 4", n); end
    n_vec++; if (eval_i !== slot(2)) begin n_err++; $display("FAIL single_eval_i_stable: wrong vector"); end
    e = sb.pop_front();
    n_vec++; if (rsp_id !== e.id) begin n_err++; $display("FAIL single_id: got %0d want %0d", rsp_id, e.id); end
    n_vec++; if (rsp_data !== e.data) begin n_err++; $display("FAIL single_data: got %h want %h", rsp_data, e.data); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_release: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
    n_vec++; if (eval_i !== slot(2)) begin n_err++; $display("FAIL single_eval_i_retain: wrong vector"); end
    ovr_en = 1'b0;
  endtask

  task automatic test_fairness;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    int got, last, cyc, k;
    exp_t e;
    do_reset();
    settle_cycles = 4'd2; rsp_ready = 1'b1; req_valid = 4'hF;
    got = 0; last = 0; cyc = 0;
    while (got < 6 && cyc < 200) begin
      #1;
      if (req_ready !== 4'b0) begin
        k = order[got];
        n_vec++; if (req_ready !== 4'(1 << k)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", got, req_ready, 4'(1 << k)); end
        if (got > 0) begin
          n_vec++; if (cyc - last != 5) begin n_err++; $display("FAIL rr_spacing%0d: got %0d want 5", got, cyc - last); end
        end
        last = cyc;
        sb.push_back('{id: ID_W'(k), data: eval_fn(slot(k))});
        got++;
      end
      if (rsp_valid === 1'b1) begin
        n_vec++;
        if (sb.size() == 0) begin n_err++; $display("FAIL rr_unexpected_rsp: got id %0d want none", rsp_id); end
        else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL rr_rsp: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
        end
      end
      step();
      cyc++;
    end
    n_vec++; if (got != 6) begin n_err++; $display("FAIL rr_count: got %0d want 6", got); end
    req_valid = 4'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      if (rsp_valid === 1'b1) begin
        e = sb.pop_front();
        n_vec++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL rr_drain: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
      end
      step();
    end
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL rr_drain_left: got %0d want 0", sb.size()); end
    rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure;
    int n, bad; exp_t e;
    do_reset();
    settle_cycles = 4'd1; rsp_ready = 1'b0; req_valid = 4'hF;
    #1;
    sb.push_back('{id: 2'd0, data: eval_fn(slot(0))});
    step();
    req_valid = 4'b1110;
    wait_rsp(n);
    n_vec++; if (n != 2) begin n_err++; $display("FAIL bp_latency: got %0d want 2", n); end
    e = sb.pop_front();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data || req_ready !== 4'b0 || busy !== 1'b1) bad++;
      step();
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    n_vec++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL bp_rsp: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got valid=%b ready=%b want 0 0010", rsp_valid, req_ready); end
    req_valid = 4'b0;
    step();
  endtask

  task automatic test_settle_zero;
    int n; exp_t e;
    do_reset();
    settle_cycles = 4'd0; req_valid = 4'b1000;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL s0_grant: got %b want 1000", req_ready); end
    sb.push_back('{id: 2'd3, data: eval_fn(slot(3))});
    step();
    req_valid = 4'b0;
    wait_rsp(n);
    n_vec++; if (n != 1) begin n_err++; $display("FAIL s0_latency: got %0d want 1", n); end
    ovr_en = 1'b1; ovr_val = {$urandom, $urandom, $urandom, $urandom};
    step();
    e = sb.pop_front();
    n_vec++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL s0_capture: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
    ovr_en = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_settle_change;
    int n; exp_t e;
    do_reset();
    settle_cycles = 4'd5; req_valid = 4'b0001;
    #1;
    sb.push_back('{id: 2'd0, data: eval_fn(slot(0))});
    step();
    req_valid = 4'b0; settle_cycles = 4'd1;
    wait_rsp(n);
    n_vec++; if (n != 6) begin n_err++; $display("FAIL settle_change_latency: got %0d want 6", n); end
    e = sb.pop_front();
    n_vec++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL settle_change_rsp: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n, bad; exp_t e;
    do_reset();
    settle_cycles = 4'd4; req_valid = 4'b0010;
    #1;
    step();
    step();
    req_valid = 4'b1010; rst = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_ctrl: got ready=%b busy=%b valid=%b want 0000 0 0", req_ready, busy, rsp_valid); end
    n_vec++; if (eval_i !== '0 || rsp_data !== '0 || rsp_id !== '0) begin n_err++; $display("FAIL midrst_data: got rsp_id %0d rsp_data %h want 0 0", rsp_id, rsp_data); end
    req_valid = 4'b0;
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid !== 1'b0) bad++;
      step();
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL midrst_no_rsp: got %0d valid cycles want 0", bad); end
    req_valid = 4'b1010;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL midrst_rr_restart: got %b want 0010", req_ready); end
    sb.push_back('{id: 2'd1, data: eval_fn(slot(1))});
    step();
    req_valid = 4'b0;
    wait_rsp(n);
    n_vec++; if (n != 5) begin n_err++; $display("FAIL midrst_latency: got %0d want 5", n); end
    e = sb.pop_front();
    n_vec++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_err++; $display("FAIL midrst_rsp: got id %0d data %h want id %0d data %h", rsp_id, rsp_data, e.id, e.data); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b0; settle_cycles = 4'd0;
    ovr_en = 1'b0; ovr_val = '0;
    for (int i = 0; i < NREQ*IN_W; i++) req_vec[i] = 1'($urandom_range(0, 1));
    #2;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_settle_zero();
    test_settle_change();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
